// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Producer side of the fetch->decode pipeline register. Generates the PC
//   stream, issues instruction-memory reads under a credit scheme, queues the
//   returned 64-bit instructions and presents the queue head combinationally
//   on ninstruction/npc. Branch redirects flush the queue and discard every
//   read still in flight.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   halt              downstream halted: queue head is not consumed
//   redirect          single-cycle redirect pulse, new PC on redirect_pc
//   req_valid/ready   memory read request handshake, address on req_addr
//   resp_valid/data   in-order read data, never back-pressured
//   ninstruction/npc  queue head instruction and its PC (STALL / 0 when empty)
//   nvalid            head is a real instruction
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating 32-bit counters:
//   perf_stall_cycles  cycles with nvalid=0 and halt=0
//   perf_fetched       instructions consumed downstream
//   perf_dropped       responses discarded after a redirect
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [63:0]       resp_data,
    output logic [63:0]       ninstruction,
    output logic [ADDR_W-1:0] npc,
    output logic              nvalid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [63:0]       STALL   = 64'h0000_0000_0000_0013;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]    DEPTH_S = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [63:0]       q_data  [DEPTH];
    logic [ADDR_W-1:0] q_pc    [DEPTH];
    logic [ADDR_W-1:0] tag_mem [DEPTH];

    logic              fire, resp_ok, discard, push, pop;
    logic [CNT_W:0]    credit_sum;

    always_comb begin
        // Queue entries plus reads in flight never exceed DEPTH, so every
        // response that is kept always finds a free queue slot.
        credit_sum   = {1'b0, cnt_q} + {1'b0, out_q};
        req_valid    = ~rst & ~redirect & (credit_sum < DEPTH_S) & (out_q < DEPTH_C);
        req_addr     = pc_q;
        nvalid       = (cnt_q != '0);
        ninstruction = nvalid ? q_data[rd_q] : STALL;
        npc          = nvalid ? q_pc[rd_q] : '0;

        fire    = req_valid & req_ready;
        // A response with nothing outstanding is a protocol error and ignored.
        resp_ok = resp_valid & (out_q != '0);
        discard = resp_ok & (redirect | (drop_q != '0));
        push    = resp_ok & ~discard;
        pop     = nvalid & ~halt & ~redirect;

        out_d    = out_q + CNT_W'(fire) - CNT_W'(resp_ok);
        tag_wr_d = tag_wr_q + PTR_W'(fire);
        pc_d     = fire ? pc_q + ADDR_W'(8) : pc_q;
        drop_d   = drop_q;
        rd_d     = rd_q + PTR_W'(pop);
        wr_d     = wr_q + PTR_W'(push);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        tag_rd_d = tag_rd_q + PTR_W'(push);

        if (redirect) begin
            // Every read still in flight after this cycle belongs to the old
            // stream; their tags are dropped by emptying the tag FIFO, so the
            // discarded responses never consume a tag.
            pc_d     = redirect_pc;
            drop_d   = out_q - CNT_W'(resp_ok);
            rd_d     = '0;
            wr_d     = '0;
            cnt_d    = '0;
            tag_rd_d = tag_wr_q;
        end else if (resp_ok && (drop_q != '0)) begin
            drop_d   = drop_q - ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    // Storage only; validity is tracked by the pointers and counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_q] <= resp_data;
            q_pc[wr_q]   <= tag_mem[tag_rd_q];
        end
        if (fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
    end

    a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        resp_valid |-> (out_q != '0));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_sum <= DEPTH_S);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] dropped_q, dropped_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        stall_cycles_d = sat_inc(stall_cycles_q, ~nvalid & ~halt);
        fetched_d      = sat_inc(fetched_q, pop);
        dropped_d      = sat_inc(dropped_q, discard);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            fetched_q      <= '0;
            dropped_q      <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fetched_q      <= fetched_d;
            dropped_q      <= dropped_d;
        end
    end

    assign perf_stall_cycles = stall_cycles_q;
    assign perf_fetched      = fetched_q;
    assign perf_dropped      = dropped_q;
`endif

endmodule

`default_nettype wire
